// File: rtl/hazard_alarm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_alarm_ctrl_pkg
// Description : Shared state codes, severity codes and severity decode for
//               the hazard alarm controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_alarm_ctrl_pkg;

  // Alarm controller state codes, also driven out on Ostate
  typedef enum logic [1:0] {
    ST_SAFE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2,
    ST_ACKED = 2'd3
  } state_t;

  // Severity codes derived from the decoder level outputs
  localparam logic [1:0] SEV_SAFE   = 2'd0;
  localparam logic [1:0] SEV_WARN   = 2'd1;
  localparam logic [1:0] SEV_HAZARD = 2'd2;

  localparam logic [3:0] ALARM_CNT_MAX = 4'd15;

  // Highest asserted level wins; no level at all is treated as a hazard so a
  // dead sensor link fails safe.
  function automatic logic [1:0] decode_sev(input logic red,
                                            input logic yellow,
                                            input logic green);
    logic [1:0] sev;
    if (red)         sev = SEV_HAZARD;
    else if (yellow) sev = SEV_WARN;
    else if (green)  sev = SEV_SAFE;
    else             sev = SEV_HAZARD;
    return sev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_blink_gen.sv
`default_nettype none
// ============================================================================
// Module      : hazard_blink_gen
// Description : Blink phase generator for the red alarm lamp. A restart pulse
//               forces the phase on and clears the divider; while enabled the
//               phase toggles every BLINK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_blink_gen #(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic phase
);

  // 8 bits covers the full divider range up to 255
  localparam logic [7:0] DIV_LAST = 8'(BLINK_DIV - 1);

  logic [7:0] cnt;

  // Divider counter and phase; restart has priority so a fresh alarm always
  // begins with the lamp on for a full half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= 8'd0;
      phase <= 1'b1;
    end else if (en) begin
      if (cnt == DIV_LAST) begin
        cnt   <= 8'd0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_alarm_ctrl
// Description : Filters red/yellow/green hazard levels into a stable alarm
//               state, latches red hazards until acknowledged, drives lamps
//               and buzzer, and counts alarm entries.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_alarm_ctrl
  import hazard_alarm_ctrl_pkg::*;
#(
  parameter int QUAL_CYCLES = 3,
  parameter int BLINK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ired,
  input  logic       Iyellow,
  input  logic       Igreen,
  input  logic       Iack,
  output logic       Olamp_red,
  output logic       Olamp_yellow,
  output logic       Olamp_green,
  output logic       Obuzzer,
  output logic [1:0] Ostate,
  output logic [3:0] Oalarm_cnt
);

  localparam logic [3:0] QUAL_LIMIT = 4'(QUAL_CYCLES);

  state_t     state;
  logic [1:0] sev;
  logic [1:0] last_sev;
  logic [3:0] run_cnt;
  logic [3:0] run_cnt_next;
  logic       qualified;
  logic       alarm_entry;
  logic       blink_phase;
  logic [3:0] alarm_cnt;

  // Current-cycle severity from the decoder levels
  always_comb begin
    sev = decode_sev(Ired, Iyellow, Igreen);
  end

  // Length of the current run of identical severities, saturating at the
  // qualification threshold
  always_comb begin
    run_cnt_next = run_cnt;
    if (sev != last_sev) begin
      run_cnt_next = 4'd1;
    end else if (run_cnt >= QUAL_LIMIT) begin
      run_cnt_next = QUAL_LIMIT;
    end else begin
      run_cnt_next = run_cnt + 4'd1;
    end
  end

  assign qualified = (run_cnt_next == QUAL_LIMIT);

  // Escalation to ALARM is only possible from SAFE or WARN; ACKED suppresses
  // re-alarm until the hazard has cleared.
  assign alarm_entry = ((state == ST_SAFE) || (state == ST_WARN)) &&
                       (sev == SEV_HAZARD);

  // Qualification history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sev <= SEV_SAFE;
      run_cnt  <= 4'd0;
    end else begin
      last_sev <= sev;
      run_cnt  <= run_cnt_next;
    end
  end

  // Alarm state machine: immediate escalation, qualified de-escalation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SAFE;
    end else begin
      case (state)
        ST_SAFE: begin
          if (sev == SEV_HAZARD) begin
            state <= ST_ALARM;
          end else if (qualified && (sev == SEV_WARN)) begin
            state <= ST_WARN;
          end
        end
        ST_WARN: begin
          if (sev == SEV_HAZARD) begin
            state <= ST_ALARM;
          end else if (qualified && (sev == SEV_SAFE)) begin
            state <= ST_SAFE;
          end
        end
        ST_ALARM: begin
          if (Iack) begin
            state <= ST_ACKED;
          end
        end
        ST_ACKED: begin
          if (qualified && (sev == SEV_SAFE)) begin
            state <= ST_SAFE;
          end else if (qualified && (sev == SEV_WARN)) begin
            state <= ST_WARN;
          end
        end
        default: begin
          state <= ST_SAFE;
        end
      endcase
    end
  end

  // Saturating count of transitions into ALARM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_cnt <= 4'd0;
    end else if (alarm_entry && (alarm_cnt != ALARM_CNT_MAX)) begin
      alarm_cnt <= alarm_cnt + 4'd1;
    end
  end

  hazard_blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (alarm_entry),
    .en      (state == ST_ALARM),
    .phase   (blink_phase)
  );

  assign Olamp_green  = (state == ST_SAFE);
  assign Olamp_yellow = (state == ST_WARN);
  assign Olamp_red    = (state == ST_ACKED) ||
                        ((state == ST_ALARM) && blink_phase);
  assign Obuzzer      = (state == ST_ALARM);
  assign Ostate       = state;
  assign Oalarm_cnt   = alarm_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_alarm_ctrl
// Description : Self-checking bench for hazard_alarm_ctrl: directed vector
//               table, hand-written saturation and async-reset sequences, and
//               randomized stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_alarm_ctrl;

  localparam int QUAL  = 3;
  localparam int BLINK = 4;

  logic       clk;
  logic       rst;
  logic       Ired;
  logic       Iyellow;
  logic       Igreen;
  logic       Iack;
  logic       Olamp_red;
  logic       Olamp_yellow;
  logic       Olamp_green;
  logic       Obuzzer;
  logic [1:0] Ostate;
  logic [3:0] Oalarm_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_alarm_ctrl #(
    .QUAL_CYCLES (QUAL),
    .BLINK_DIV   (BLINK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Ired         (Ired),
    .Iyellow      (Iyellow),
    .Igreen       (Igreen),
    .Iack         (Iack),
    .Olamp_red    (Olamp_red),
    .Olamp_yellow (Olamp_yellow),
    .Olamp_green  (Olamp_green),
    .Obuzzer      (Obuzzer),
    .Ostate       (Ostate),
    .Oalarm_cnt   (Oalarm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vector record: inputs then expected state, red lamp, count
  typedef struct {
    logic r;
    logic y;
    logic g;
    logic a;
    int   st;
    int   red;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic y, input logic g,
                     input logic a, input int st, input int red, input int cnt);
    vec_t v;
    v.r = r; v.y = y; v.g = g; v.a = a;
    v.st = st; v.red = red; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Lamps and buzzer follow directly from the expected state code
  task automatic check_outs(input string tag, input int st, input int red,
                            input int cnt);
    chk({tag, " state"},  int'(Ostate),       st);
    chk({tag, " green"},  int'(Olamp_green),  (st == 0) ? 1 : 0);
    chk({tag, " yellow"}, int'(Olamp_yellow), (st == 1) ? 1 : 0);
    chk({tag, " red"},    int'(Olamp_red),    red);
    chk({tag, " buzzer"}, int'(Obuzzer),      (st == 2) ? 1 : 0);
    chk({tag, " count"},  int'(Oalarm_cnt),   cnt);
  endtask

  task automatic drive(input logic r, input logic y, input logic g,
                       input logic a);
    Ired = r; Iyellow = y; Igreen = g; Iack = a;
  endtask

  // Apply inputs across one rising edge and settle just after it
  task automatic step(input logic r, input logic y, input logic g,
                      input logic a);
    drive(r, y, g, a);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_state;
  int m_since;
  int m_entries;
  int hist[$];

  task automatic model_reset();
    m_state   = 0;
    m_since   = 0;
    m_entries = 0;
    hist.delete();
  endtask

  // A severity is qualified when the last QUAL samples since reset all equal it
  task automatic model_edge(input logic r, input logic y, input logic g,
                            input logic a);
    int sev;
    int nxt;
    bit qual;
    sev = r ? 2 : (y ? 1 : (g ? 0 : 2));
    hist.push_back(sev);
    if (hist.size() > QUAL) void'(hist.pop_front());
    qual = (hist.size() == QUAL);
    foreach (hist[i]) if (hist[i] != sev) qual = 1'b0;
    nxt = m_state;
    case (m_state)
      0: if (sev == 2) nxt = 2; else if (qual && sev == 1) nxt = 1;
      1: if (sev == 2) nxt = 2; else if (qual && sev == 0) nxt = 0;
      2: if (a) nxt = 3;
      default: if (qual && sev == 0) nxt = 0; else if (qual && sev == 1) nxt = 1;
    endcase
    if (nxt == 2 && m_state != 2) begin
      m_entries++;
      m_since = 0;
    end else if (nxt == 2) begin
      m_since++;
    end
    m_state = nxt;
  endtask

  function automatic int model_red();
    if (m_state == 3) return 1;
    if (m_state == 2) return ((m_since / BLINK) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic int model_cnt();
    return (m_entries > 15) ? 15 : m_entries;
  endfunction

  initial begin
    int pat[8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    int exp_cnt;
    int hold;
    logic r, y, g, a;

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2, 1, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 2, pat[i], 1);
    add(0, 0, 1, 1, 3, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 2, 1, 2);
    add(0, 0, 1, 0, 2, 1, 2);
    add(0, 0, 1, 1, 3, 1, 2);
    add(1, 0, 0, 0, 3, 1, 2);
    add(0, 0, 1, 0, 3, 1, 2);
    add(0, 0, 1, 0, 3, 1, 2);
    add(0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 1, 2, 1, 3);
    add(1, 0, 0, 1, 3, 1, 3);
    add(0, 1, 0, 0, 3, 1, 3);
    add(0, 1, 0, 0, 3, 1, 3);
    add(0, 1, 0, 0, 1, 0, 3);
    add(0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 1, 0, 0, 0, 3);

    // ---------------- reset ----------------
    rst = 1'b1;
    drive(0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_held", 0, 0, 0);
    rst = 1'b0;
    #1;
    check_outs("reset_released", 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].a);
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].red, tbl[i].cnt);
    end

    // ---------------- alarm counter saturation ----------------
    exp_cnt = 3;
    for (int k = 0; k < 16; k++) begin
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      step(1, 0, 0, 0);
      check_outs($sformatf("sat%0d_alarm", k), 2, 1, exp_cnt);
      step(0, 0, 1, 1);
      check_outs($sformatf("sat%0d_ack", k), 3, 1, exp_cnt);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check_outs($sformatf("sat%0d_clear", k), 0, 0, exp_cnt);
    end

    // ---------------- async reset mid-ALARM ----------------
    step(1, 0, 0, 0);
    check_outs("pre_async", 2, 1, 15);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0);
    rst = 1'b0;
    model_reset();

    // ---------------- randomized vs model ----------------
    for (int n = 0; n < 2000; n += hold) begin
      hold = $urandom_range(1, 6);
      r = ($urandom_range(0, 3) == 0);
      y = ($urandom_range(0, 2) == 0);
      g = ($urandom_range(0, 3) != 0);
      for (int h = 0; h < hold; h++) begin
        a = ($urandom_range(0, 3) == 0);
        step(r, y, g, a);
        model_edge(r, y, g, a);
        check_outs("rand", m_state, model_red(), model_cnt());
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
